uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver: recovers 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit) from an asynchronous serial line. It is the downstream counterpart of the team's UART transmitter and uses the same frame format and baud parameterisation. It oversamples the line, rejects start-bit glitches, flags framing errors, and presents each received byte with a one-cycle valid strobe to the parallel-side logic.

## Interface
- CLK_FRQ, 50000000, system clock frequency in Hz
- BAUD_RATE, 115200, line bit rate in bits/s
- OVERSAMPLE, 16, sample ticks per bit period; even, ≥ 4
- clk  input  1  system clock; all logic on rising edge
- areset  input  1  reset; asynchronous, active-high
- data_in  input  1  serial line, asynchronous to clk, idles high
- data_out  output  8  last correctly framed byte
- rx_valid  output  1  one-cycle pulse: data_out updated with a new byte
- frame_err  output  1  one-cycle pulse: stop bit sampled low, byte discarded
- rx_busy  output  1  high while a frame is in progress (START/DATA/STOP)

## Operation
- Synchroniser: 2-flop chain on data_in, both flops reset to 1. All logic uses the synchronised value `rxs`. A registered copy `rxs_d` of rxs is used for edge detection.
- Sample tick: a free-running counter runs from 0 to SAMPLE_DIV-1, where SAMPLE_DIV = CLK_FRQ / (BAUD_RATE*OVERSAMPLE), using integer division and clamped to a minimum of 1. The tick strobe is high for one clk when the counter wraps. Counter width is 32 bits. Reset clears the counter.
- Tick counter `tcnt`: width $clog2(OVERSAMPLE). Bit counter `bcnt`: 0..8.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - On a tick with rxs==0 and the previous tick-sampled value ==1 (a falling edge), clear tcnt and go to START.
  - A line held low never re-arms the FSM. It must return high first.
- START:
  - On each tick, increment tcnt.
  - When tcnt reaches OVERSAMPLE/2-1 (mid start bit):
    - If rxs==0: clear tcnt and bcnt, go to DATA.
    - Otherwise the start bit is a glitch: go to IDLE with no output pulse.
- DATA:
  - On each tick, increment tcnt, which wraps at OVERSAMPLE-1.
  - When tcnt reaches OVERSAMPLE-1 (mid data bit): shift rxs into the MSB of the 8-bit shift register (right shift, LSB first), then increment bcnt.
  - When the 8th bit has been sampled, go to STOP.
- STOP:
  - At the next mid-bit point (OVERSAMPLE ticks later):
    - If rxs==1: data_out <= shift register, rx_valid <= 1.
    - Otherwise: frame_err <= 1, and data_out keeps its value.
  - In both cases go to IDLE.
  - The previous-sample register is set to the stop sample, so a low stop bit (break) does not immediately re-arm the FSM.
- rx_valid and frame_err are never high in the same cycle. Each is high for exactly one clk per frame.
- rx_busy is registered and equals (state != IDLE).
- Unreachable state encodings return to IDLE with outputs deasserted.

## Timing
- Reset values: data_out=8'h00, rx_valid=0, frame_err=0, rx_busy=0, state=IDLE, shift register=0, synchroniser=1.
- Reset asserted mid-frame aborts immediately with no pulse. The next frame requires a fresh high-to-low transition after reset is released.
- Input latency: 2 clk (synchroniser) plus up to SAMPLE_DIV clk (tick phase).
- Sample points sit OVERSAMPLE/2 ticks (±1 tick) after each bit edge.
- rx_valid/frame_err rise 1 clk after the tick that samples the stop bit. This is about 9.5 bit periods after the start-bit falling edge.
- Back-to-back frames are supported:
  - The STOP→IDLE transition occurs at mid stop bit.
  - The next start edge is accepted on any later tick.
- Tolerated baud mismatch between transmitter and receiver: at least ±3%.

## Test plan
Bench parameters are CLK_FRQ=1600, BAUD_RATE=100, OVERSAMPLE=16. This gives SAMPLE_DIV=1 and one bit = 16 clk.
- Send frame 0xA5 with stop bit 1 → exactly one rx_valid pulse, data_out=8'hA5, frame_err never high, rx_busy high ~150 clk then 0.
- Glitch: pull the line low for 4 clk, then idle high for 200 clk → no rx_valid or frame_err; rx_busy returns to 0 within 10 clk of the glitch.
- Send 0x3C with stop bit 0, after a prior 0xA5 → exactly one frame_err pulse, no rx_valid, data_out stays 8'hA5.
- Send 0x00 then 0xFF back-to-back with no idle gap → two rx_valid pulses, 160 clk ±2 apart, data_out 8'h00 then 8'hFF.
- Assert areset after 4 data bits of a 0x81 frame, release it, then send 0x5A → no pulse for the aborted frame, all outputs at reset values during reset, one rx_valid with data_out=8'h5A.
- Break: hold the line low for 30 bit periods, then high, then send 0x42 → exactly one frame_err, then one rx_valid with 8'h42.

Source files
------------

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// uart_rx : 8N1 UART receiver, oversampled, glitch-rejecting, framing check
// Rev 1.0
// ============================================================================
module uart_rx #(
  parameter int CLK_FRQ    = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       areset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int c_DIV_RAW    = CLK_FRQ / (BAUD_RATE * OVERSAMPLE);
  localparam int c_SAMPLE_DIV = (c_DIV_RAW < 1) ? 1 : c_DIV_RAW;
  localparam int c_TW         = $clog2(OVERSAMPLE);

  localparam logic [31:0]     c_DIV_M1  = 32'(c_SAMPLE_DIV - 1);
  localparam logic [c_TW-1:0] c_HALF_M1 = c_TW'(OVERSAMPLE / 2 - 1);
  localparam logic [c_TW-1:0] c_FULL_M1 = c_TW'(OVERSAMPLE - 1);
  localparam logic [3:0]      c_LAST_BIT = 4'd7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic            sync1_q;
  logic            rxs_q;
  logic            rxs_prev_q, rxs_prev_d;
  logic [31:0]     div_q;
  logic            w_tick;

  state_t          state_q, state_d;
  logic [c_TW-1:0] tcnt_q, tcnt_d;
  logic [3:0]      bcnt_q, bcnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            busy_q, busy_d;

  // Synchroniser and free-running sample-tick divider.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
      div_q   <= '0;
    end else begin
      sync1_q <= data_in;
      rxs_q   <= sync1_q;
      div_q   <= w_tick ? '0 : div_q + 32'd1;
    end
  end

  assign w_tick = (div_q == c_DIV_M1);

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q    <= S_IDLE;
      rxs_prev_q <= 1'b1;
      tcnt_q     <= '0;
      bcnt_q     <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rxs_prev_q <= rxs_prev_d;
      tcnt_q     <= tcnt_d;
      bcnt_q     <= bcnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tcnt_d     = tcnt_q;
    bcnt_d     = bcnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
    // Tick-sampled line history; after a low stop bit it stays 0, so a
    // held-low line cannot re-arm until it has gone high again.
    rxs_prev_d = w_tick ? rxs_q : rxs_prev_q;

    case (state_q)
      S_IDLE: begin
        if (w_tick && !rxs_q && rxs_prev_q) begin
          tcnt_d  = '0;
          state_d = S_START;
        end
      end

      S_START: begin
        if (w_tick) begin
          if (tcnt_q == c_HALF_M1) begin
            if (!rxs_q) begin
              tcnt_d  = '0;
              bcnt_d  = '0;
              state_d = S_DATA;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end

      S_DATA: begin
        if (w_tick) begin
          if (tcnt_q == c_FULL_M1) begin
            tcnt_d  = '0;
            shift_d = {rxs_q, shift_q[7:1]};
            bcnt_d  = bcnt_q + 4'd1;
            if (bcnt_q == c_LAST_BIT) begin
              state_d = S_STOP;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end

      S_STOP: begin
        if (w_tick) begin
          if (tcnt_q == c_FULL_M1) begin
            tcnt_d = '0;
            if (rxs_q) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
            state_d = S_IDLE;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        tcnt_d  = '0;
        bcnt_d  = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign data_out  = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign rx_busy   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// tb_uart_rx : directed 8N1 frames checked each cycle against an event model
// Rev 1.0
// ============================================================================
module tb_uart_rx;

  localparam int CLK_FRQ    = 1600;
  localparam int BAUD_RATE  = 100;
  localparam int OVERSAMPLE = 16;
  localparam int BIT_CLK    = 16;
  // Start bit driven just after edge n: 2 sync + 1 edge detect + 8 half bit
  // + 9 full bits to mid stop = edge n+155 registers the pulse.
  localparam int LAT_PULSE  = 155;
  localparam int BUSY_ON    = 3;
  localparam int GLITCH_OFF = 10;

  logic       clk = 1'b0;
  logic       areset;
  logic       data_in;
  logic [7:0] data_out;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;

  uart_rx #(
    .CLK_FRQ   (CLK_FRQ),
    .BAUD_RATE (BAUD_RATE),
    .OVERSAMPLE(OVERSAMPLE)
  ) dut (
    .clk      (clk),
    .areset   (areset),
    .data_in  (data_in),
    .data_out (data_out),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .rx_busy  (rx_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    bit         ok;
    logic [7:0] b;
  } evt_t;

  typedef struct {
    int lo;
    int hi;
  } win_t;

  evt_t evq[$];
  win_t winq[$];
  logic [7:0] m_byte = 8'h00;

  int n_vec = 0;
  int n_bad = 0;
  int n_valid_seen = 0;
  int n_ferr_seen = 0;
  int first_valid_cyc = -1;
  int last_valid_cyc = -1;
  int prev_valid_cyc = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s at cyc %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle compare against the expectation model.
  always @(negedge clk) begin
    logic e_valid, e_ferr, e_busy;
    e_valid = 1'b0;
    e_ferr  = 1'b0;
    e_busy  = 1'b0;
    if (areset) begin
      evq.delete();
      winq.delete();
      m_byte = 8'h00;
    end else begin
      if (evq.size() > 0 && evq[0].due == cyc) begin
        if (evq[0].ok) begin
          e_valid = 1'b1;
          m_byte  = evq[0].b;
        end else begin
          e_ferr = 1'b1;
        end
        void'(evq.pop_front());
      end
      while (winq.size() > 0 && winq[0].hi < cyc) void'(winq.pop_front());
      foreach (winq[i])
        if (cyc >= winq[i].lo && cyc <= winq[i].hi) e_busy = 1'b1;
    end
    check("rx_valid",  32'(rx_valid),  32'(e_valid));
    check("frame_err", 32'(frame_err), 32'(e_ferr));
    check("rx_busy",   32'(rx_busy),   32'(e_busy));
    check("data_out",  32'(data_out),  32'(m_byte));
    if (rx_valid === 1'b1) begin
      n_valid_seen++;
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = cyc;
    end
    if (frame_err === 1'b1) n_ferr_seen++;
  end

  task automatic idle(input int n);
    data_in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    data_in = b;
    repeat (BIT_CLK) @(posedge clk);
    #1;
  endtask

  // ndata < 8 drives a truncated frame (no stop bit).
  task automatic send_frame(input logic [7:0] b, input logic stop, input int ndata);
    int n = cyc;
    evq.push_back('{due: n + LAT_PULSE, ok: stop, b: b});
    winq.push_back('{lo: n + BUSY_ON, hi: n + LAT_PULSE - 1});
    drive_bit(1'b0);
    for (int i = 0; i < ndata; i++) drive_bit(b[i]);
    if (ndata == 8) drive_bit(stop);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    areset  = 1'b1;
    data_in = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rst data_out",  32'(data_out),  32'h00);
    check("rst rx_valid",  32'(rx_valid),  32'h0);
    check("rst frame_err", 32'(frame_err), 32'h0);
    check("rst rx_busy",   32'(rx_busy),   32'h0);
    areset = 1'b0;
    idle(32);

    // Good frame
    n0 = cyc;
    send_frame(8'hA5, 1'b1, 8);
    idle(16);
    check("A5 valid count", n_valid_seen, 1);
    check("A5 ferr count",  n_ferr_seen, 0);
    check("A5 data_out",    32'(data_out), 32'hA5);
    check("A5 latency",     first_valid_cyc - n0, 155);

    // Start-bit glitch
    n0 = cyc;
    winq.push_back('{lo: n0 + BUSY_ON, hi: n0 + GLITCH_OFF});
    data_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle(200);
    check("glitch valid count", n_valid_seen, 1);
    check("glitch ferr count",  n_ferr_seen, 0);
    check("glitch busy",        32'(rx_busy), 32'h0);

    // Framing error keeps the previous byte
    send_frame(8'h3C, 1'b0, 8);
    idle(16);
    check("3C ferr count",  n_ferr_seen, 1);
    check("3C valid count", n_valid_seen, 1);
    check("3C data_out",    32'(data_out), 32'hA5);

    // Back-to-back frames
    send_frame(8'h00, 1'b1, 8);
    send_frame(8'hFF, 1'b1, 8);
    idle(16);
    check("b2b valid count", n_valid_seen, 3);
    check("b2b spacing",     last_valid_cyc - prev_valid_cyc, 160);
    check("b2b data_out",    32'(data_out), 32'hFF);

    // Reset mid-frame
    send_frame(8'h81, 1'b1, 4);
    areset  = 1'b1;
    data_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midrst data_out",  32'(data_out),  32'h00);
    check("midrst rx_valid",  32'(rx_valid),  32'h0);
    check("midrst frame_err", 32'(frame_err), 32'h0);
    check("midrst rx_busy",   32'(rx_busy),   32'h0);
    repeat (2) @(posedge clk);
    #1;
    areset = 1'b0;
    idle(32);
    send_frame(8'h5A, 1'b1, 8);
    idle(16);
    check("5A valid count", n_valid_seen, 4);
    check("5A ferr count",  n_ferr_seen, 1);
    check("5A data_out",    32'(data_out), 32'h5A);

    // Break: 30 bit periods low, one framing error, no re-arm while low
    n0 = cyc;
    evq.push_back('{due: n0 + LAT_PULSE, ok: 1'b0, b: 8'h00});
    winq.push_back('{lo: n0 + BUSY_ON, hi: n0 + LAT_PULSE - 1});
    data_in = 1'b0;
    repeat (30 * BIT_CLK) @(posedge clk);
    #1;
    idle(48);
    check("break ferr count",  n_ferr_seen, 2);
    check("break valid count", n_valid_seen, 4);
    send_frame(8'h42, 1'b1, 8);
    idle(16);
    check("42 valid count", n_valid_seen, 5);
    check("42 ferr count",  n_ferr_seen, 2);
    check("42 data_out",    32'(data_out), 32'h42);
    check("model drained",  evq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
